// File: rtl/action_selector_if.sv
// Request/result bundle between the Q-learning controller and the epsilon-greedy action selector.
// Handshake: start is a one-cycle request, taken only while busy=0 and no result pulse is present; the
// result is qualified by a one-cycle action_valid pulse, and action_out/explored hold until the next result.
interface action_selector_if #(
  parameter int N_ACT = 4,
  parameter int QW    = 16
);
  logic                  start;
  logic [N_ACT*QW-1:0]   q_row;
  logic [7:0]            epsilon;
  logic [3:0]            action_out;
  logic                  action_valid;
  logic                  explored;
  logic                  busy;
  logic [1:0]            dbg_state;
  logic [15:0]           dbg_lfsr;

  modport master (
    output start, q_row, epsilon,
    input  action_out, action_valid, explored, busy, dbg_state, dbg_lfsr
  );

  modport slave (
    input  start, q_row, epsilon,
    output action_out, action_valid, explored, busy, dbg_state, dbg_lfsr
  );
endinterface

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: scans one Q value per cycle for the signed maximum and
// replaces it with an LFSR-chosen action when the captured random byte falls below epsilon.
module action_selector #(
  parameter int          N_ACT     = 4,
  parameter int          QW        = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  action_selector_if.slave  sel
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [15:0]            lfsr;
  logic                   lfsr_fb;
  logic [N_ACT*QW-1:0]    q_cap;
  logic [7:0]             eps_cap;
  logic [7:0]             rnd;
  logic [3:0]             ract;
  logic [3:0]             idx;
  logic [3:0]             best_idx;
  logic signed [QW-1:0]   best_val;
  logic signed [QW-1:0]   cur_val;
  logic                   accept;
  logic                   valid_q;
  logic                   explored_q;
  logic [3:0]             action_q;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cur_val = q_cap[idx*QW +: QW];

  // The result-pulse cycle is not an accept slot, so a held start re-arms one cycle later.
  assign accept = sel.start && !valid_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (idx >= 4'(N_ACT - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      q_cap      <= '0;
      eps_cap    <= '0;
      rnd        <= '0;
      ract       <= '0;
      idx        <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      valid_q    <= 1'b0;
      explored_q <= 1'b0;
      action_q   <= '0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_cap    <= sel.q_row;
            eps_cap  <= sel.epsilon;
            rnd      <= lfsr[7:0];
            ract     <= 4'({2'b00, lfsr[9:8]} % N_ACT);
            best_idx <= '0;
            best_val <= sel.q_row[QW-1:0];
            idx      <= 4'd1;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (cur_val > best_val) begin
            best_val <= cur_val;
            best_idx <= idx;
          end
          idx <= idx + 4'd1;
        end
        DONE: begin
          valid_q <= 1'b1;
          if (rnd < eps_cap) begin
            action_q   <= ract;
            explored_q <= 1'b1;
          end else begin
            action_q   <= best_idx;
            explored_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel.action_out   = action_q;
  assign sel.action_valid = valid_q;
  assign sel.explored     = explored_q;
  assign sel.busy         = (state != IDLE);
  assign sel.dbg_state    = state;
  assign sel.dbg_lfsr     = lfsr;

endmodule

// File: tb/tb_action_selector.sv
// Self-checking bench for action_selector: reference LFSR and greedy model feed an expected queue
// that is popped against each action_valid pulse.
module tb_action_selector;
  localparam int          N_ACT = 4;
  localparam int          QW    = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  action_selector_if #(.N_ACT(N_ACT), .QW(QW)) sel ();

  action_selector #(.N_ACT(N_ACT), .QW(QW), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .sel (sel)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  exp_q[$];
  logic [15:0] m_lfsr;

  // Reference LFSR, taps 16,14,13,11.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] greedy(input logic [N_ACT*QW-1:0] q);
    logic signed [QW-1:0] bv;
    logic signed [QW-1:0] v;
    logic [3:0]           bi;
    bv = q[QW-1:0];
    bi = 4'd0;
    for (int k = 1; k < N_ACT; k++) begin
      v = q[k*QW +: QW];
      if (v > bv) begin
        bv = v;
        bi = 4'(k);
      end
    end
    return bi;
  endfunction

  function automatic logic [4:0] predict(input logic [N_ACT*QW-1:0] q, input logic [7:0] eps,
                                         input logic [15:0] lf);
    logic [1:0] r;
    r = lf[9:8];
    if (lf[7:0] < eps) return {1'b1, 4'(r % N_ACT)};
    return {1'b0, greedy(q)};
  endfunction

  // Drives a request at the current negedge and records its expected result.
  task automatic send_req(input logic [N_ACT*QW-1:0] q, input logic [7:0] eps);
    sel.start   = 1'b1;
    sel.q_row   = q;
    sel.epsilon = eps;
    exp_q.push_back(predict(q, eps, m_lfsr));
  endtask

  // Waits for action_valid; lat is negedges since the request (-1 on timeout).
  task automatic wait_valid(input int k0, output int lat, output logic [4:0] got);
    lat = -1;
    got = '0;
    for (int k = k0 + 1; k <= 12; k++) begin
      @(negedge clk);
      sel.start = 1'b0;
      if (sel.action_valid) begin
        lat = k;
        got = {sel.explored, sel.action_out};
        break;
      end
    end
  endtask

  function automatic logic [4:0] pop_exp();
    if (exp_q.size() == 0) return 5'h1F;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    sel.start   = 1'b0;
    sel.q_row   = '0;
    sel.epsilon = 8'd0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sel.action_valid, sel.explored, sel.busy, sel.action_out} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000",
               {sel.action_valid, sel.explored, sel.busy, sel.action_out});
    end
    checks++;
    if (sel.dbg_lfsr !== SEED) begin
      errors++;
      $display("FAIL reset_lfsr got %h exp %h", sel.dbg_lfsr, SEED);
    end
    checks++;
    if (sel.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d exp 0", sel.dbg_state);
    end
  endtask

  task automatic test_explore();
    int         lat;
    logic [4:0] got;
    logic [4:0] e;
    rst = 1'b0;
    send_req({16'd1, 16'd2, 16'd3, 16'd4}, 8'd255);
    wait_valid(0, lat, got);
    e = pop_exp();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL explore_latency got %0d exp 5", lat); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL explore_model got %h exp %h", got, e); end
    checks++;
    if (got !== 5'h10) begin errors++; $display("FAIL explore_seed got %h exp 10", got); end
  endtask

  task automatic test_greedy();
    int         lat;
    logic [4:0] got;
    logic [4:0] e;
    @(negedge clk);
    send_req({16'd5, 16'd40, 16'd7, 16'd3}, 8'd0);
    wait_valid(0, lat, got);
    e = pop_exp();
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL greedy_latency got %0d exp 5", lat); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL greedy_model got %h exp %h", got, e); end
    checks++;
    if (got !== 5'h02) begin errors++; $display("FAIL greedy_value got %h exp 02", got); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({sel.action_valid, sel.explored, sel.action_out} !== 6'b0_0_0010) begin
        errors++;
        $display("FAIL greedy_hold got %b exp 000010",
                 {sel.action_valid, sel.explored, sel.action_out});
      end
    end
  endtask

  task automatic test_signed_ties();
    int         lat;
    logic [4:0] got;
    logic [4:0] e;
    @(negedge clk);
    send_req({16'hFFFF, 16'h8000, 16'hFFF0, 16'hFFF0}, 8'd0);
    wait_valid(0, lat, got);
    e = pop_exp();
    checks++;
    if (got !== e || got !== 5'h03) begin
      errors++;
      $display("FAIL signed_cmp got %h exp %h", got, e);
    end
    @(negedge clk);
    send_req({4{16'h0010}}, 8'd0);
    wait_valid(0, lat, got);
    e = pop_exp();
    checks++;
    if (got !== e || got !== 5'h00 || lat !== 5) begin
      errors++;
      $display("FAIL tie_low_index got %h lat %0d exp %h lat 5", got, lat, e);
    end
  endtask

  task automatic test_isolation();
    int         lat;
    logic [4:0] got;
    logic [4:0] e;
    @(negedge clk);
    send_req({16'd1, 16'd2, 16'd9, 16'd4}, 8'd0);
    @(negedge clk);
    sel.start   = 1'b0;
    sel.q_row   = {4{16'h7FFF}};
    sel.epsilon = 8'd255;
    wait_valid(1, lat, got);
    e = pop_exp();
    checks++;
    if (got !== e || got !== 5'h01) begin
      errors++;
      $display("FAIL isolation got %h exp %h", got, e);
    end
  endtask

  task automatic test_random();
    int                  lat;
    logic [4:0]          got;
    logic [4:0]          e;
    logic [N_ACT*QW-1:0] q;
    logic [7:0]          eps;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N_ACT; k++) q[k*QW +: QW] = 16'($urandom_range(0, 65535));
      eps = (i == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      @(negedge clk);
      send_req(q, eps);
      wait_valid(0, lat, got);
      e = pop_exp();
      checks++;
      if (lat !== 5 || got !== e) begin
        errors++;
        $display("FAIL random_%0d got %h lat %0d exp %h lat 5 eps %0d", i, got, lat, e, eps);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    logic       exp_valid;
    logic       exp_busy;
    int         pulses;
    int         first;
    int         last;
    pulses = 0;
    first  = -1;
    last   = -1;
    @(negedge clk);
    send_req({16'd0, 16'd3, 16'd100, 16'd50}, 8'd0);
    exp_q.push_back({1'b0, greedy({16'd0, 16'd3, 16'd100, 16'd50})});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 10) sel.start = 1'b0;
      exp_valid = (k == 5) || (k == 11);
      exp_busy  = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
      checks++;
      if ({sel.action_valid, sel.busy} !== {exp_valid, exp_busy}) begin
        errors++;
        $display("FAIL b2b_cycle_%0d valid/busy got %b exp %b", k,
                 {sel.action_valid, sel.busy}, {exp_valid, exp_busy});
      end
      if (sel.action_valid) begin
        pulses++;
        if (first < 0) first = k;
        last = k;
        e = pop_exp();
        checks++;
        if ({sel.explored, sel.action_out} !== e) begin
          errors++;
          $display("FAIL b2b_result got %h exp %h", {sel.explored, sel.action_out}, e);
        end
      end
    end
    checks++;
    if (pulses !== 2 || (last - first) !== 6) begin
      errors++;
      $display("FAIL b2b_pulses got %0d apart %0d exp 2 apart 6", pulses, last - first);
    end
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    pulses = 0;
    @(negedge clk);
    sel.start   = 1'b1;
    sel.q_row   = {16'd0, 16'd0, 16'd0, 16'd7};
    sel.epsilon = 8'd0;
    @(negedge clk);
    sel.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({sel.action_valid, sel.explored, sel.busy, sel.action_out} !== 7'd0) begin
      errors++;
      $display("FAIL midscan_outputs got %b exp 0000000",
               {sel.action_valid, sel.explored, sel.busy, sel.action_out});
    end
    checks++;
    if (sel.dbg_lfsr !== SEED) begin
      errors++;
      $display("FAIL midscan_lfsr got %h exp %h", sel.dbg_lfsr, SEED);
    end
    for (int k = 4; k <= 12; k++) begin
      @(negedge clk);
      if (sel.action_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midscan_abort pulses got %0d exp 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_explore();
    test_greedy();
    test_signed_ties();
    test_isolation();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/action_selector.md
ACTION_SELECTOR -- requirements
Module: action_selector

Interface
REQ-001 SHALL have parameter N_ACT, default 4, meaning the number of actions per Q row.
REQ-002 SHALL have parameter QW, default 16, meaning the signed Q-value width.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero LFSR reset value.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: selection request, sampled only in IDLE.
REQ-007 SHALL have port q_row, input, N_ACT*QW bits: Q values of the current state; action k occupies bits [k*QW+QW-1 : k*QW].
REQ-008 SHALL have port epsilon, input, 8 bits: exploration threshold, out of 256.
REQ-009 SHALL have port action_out, output, 4 bits: selected action index, which drives current_action of the Q-learning datapath.
REQ-010 SHALL have port action_valid, output, 1 bit: one-cycle pulse qualifying action_out.
REQ-011 SHALL have port explored, output, 1 bit: high when the last selection was random; qualified by action_valid.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL contain a 16-bit Fibonacci LFSR with taps 16,14,13,11, stepping every non-reset cycle; shift left, new bit into bit 0.
REQ-014 SHALL implement the states IDLE, SCAN and DONE.
REQ-015 SHALL, in IDLE with start=1, register q_row, epsilon, rnd=lfsr[7:0] and ract=lfsr[9:8] (modulo N_ACT), set best_idx=0 and best_val=Q[0], set scan index to 1, and move to SCAN.
REQ-016 SHALL, in SCAN, process one index per cycle: if signed Q[idx] > best_val, then best_val=Q[idx] and best_idx=idx; the index then increments.
REQ-017 SHALL leave SCAN for DONE after index N_ACT-1 has been processed (N_ACT-1 cycles in SCAN).
REQ-018 SHALL use strict greater-than in the comparison, so ties resolve to the lowest index.
REQ-019 SHALL, in DONE, set action_out=ract and explored=1 when rnd < epsilon; otherwise action_out=best_idx and explored=0.
REQ-020 SHALL pulse action_valid for exactly one cycle and return to IDLE in the same transition.
REQ-021 SHALL have a latency, with default N_ACT, of action_valid high in the 5th cycle after the edge that samples start; the next start can be accepted in the cycle after that.
REQ-022 SHALL ignore start while busy=1; no queueing.
REQ-023 SHALL ignore changes on q_row and epsilon after capture.
REQ-024 SHALL never explore when epsilon=0.
REQ-025 SHALL explore for every rnd except 255 when epsilon=255.
REQ-026 SHALL hold action_out and explored until the next DONE.
REQ-027 SHALL treat Q values as two's complement: 16'h8000 is the minimum and 16'h7FFF is the maximum.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set state=IDLE, action_out=0, action_valid=0, explored=0, busy=0, lfsr=LFSR_SEED, and clear the captured registers.
REQ-029 SHALL, when reset occurs in SCAN or DONE, abort the operation so that no action_valid pulse follows; start is honoured on the first cycle with rst=0.

Verification
REQ-030 SHALL verify the greedy case: epsilon=0, q_row={16'd5,16'd40,16'd7,16'd3} (Q3..Q0) -> action_out=2, explored=0, action_valid in the 5th cycle after start.
REQ-031 SHALL verify signed comparison and ties: epsilon=0, Q0=16'hFFF0, Q1=16'hFFF0, Q2=16'h8000, Q3=16'hFFFF -> action_out=3; then all Q equal to 16'h0010 -> action_out=0.
REQ-032 SHALL verify exploration: epsilon=255 after reset, start on the first cycle -> explored=1 (rnd=8'hE1 from the seed) and action_out=lfsr[9:8] of the seed (=0); a scoreboard models the LFSR.
REQ-033 SHALL verify busy protection: start held high for 10 cycles -> exactly two action_valid pulses, 6 cycles apart, and busy low only in the cycles between.
REQ-034 SHALL verify reset mid-SCAN: rst=1 for 1 cycle two cycles after start -> no action_valid, all outputs 0, and lfsr equal to 16'hACE1 on the cycle after reset.
REQ-035 SHALL verify input isolation: q_row changed to all 16'h7FFF one cycle after start -> the result reflects the captured row.
